// File: rtl/frame_scanner.sv
// frame_scanner: reads the frame RAM in raster order and drives the VGA plot interface, one frame per start
// Build option: define FRAME_SCANNER_TRANSPARENT_EN to suppress plots of pixels whose colour equals KEY_COLOR.
module frame_scanner #(
    parameter int            WIDTH     = 160,
    parameter int            HEIGHT    = 120,
    parameter int            cbit      = 11,
    parameter int            RD_LAT    = 1,
    parameter logic [cbit:0] KEY_COLOR = '0
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          enable,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [14:0]   addr,
    output logic          wren,
    input  logic [cbit:0] q,
    output logic [7:0]    VGA_X,
    output logic [6:0]    VGA_Y,
    output logic [cbit:0] VGA_COLOR,
    output logic          plot
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    localparam logic [7:0] XMAX = 8'(WIDTH - 1);
    localparam logic [6:0] YMAX = 7'(HEIGHT - 1);
    localparam logic [1:0] DMAX = 2'(RD_LAT - 1);

    state_t        r_state, w_next;
    logic          w_issue, w_last, w_show;
    logic          r_arm;
    logic [1:0]    r_dcnt;
    logic [7:0]    r_x;
    logic [6:0]    r_y;
    logic [14:0]   r_addr;
    logic          r_pv [RD_LAT];
    logic [7:0]    r_px [RD_LAT];
    logic [6:0]    r_py [RD_LAT];
    logic [7:0]    r_vx;
    logic [6:0]    r_vy;
    logic [cbit:0] r_vc;
    logic          r_plot;

`ifdef FRAME_SCANNER_TRANSPARENT_EN
    assign w_show = q != KEY_COLOR;
`else
    logic w_unused_key;
    assign w_unused_key = ^KEY_COLOR;
    assign w_show = 1'b1;
`endif

    assign busy      = r_state == SCAN || r_state == DRAIN;
    assign done      = r_state == DONE;
    assign wren      = 1'b0;
    assign addr      = r_addr;
    assign VGA_X     = r_vx;
    assign VGA_Y     = r_vy;
    assign VGA_COLOR = r_vc;
    assign plot      = r_plot;

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Next state; a read issues in every enabled SCAN cycle, DRAIN lasts RD_LAT cycles
    always_comb begin
        w_issue = r_state == SCAN && enable;
        w_last  = w_issue && r_x == XMAX && r_y == YMAX;
        w_next  = r_state == IDLE  ? (start && r_arm ? SCAN : IDLE) :
                  r_state == SCAN  ? (w_last ? DRAIN : SCAN) :
                  r_state == DRAIN ? (r_dcnt == DMAX ? DONE : DRAIN) : IDLE;
    end

    // Raster counters and incremental address; r_arm blocks a start coincident with reset release
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_arm  <= 1'b0;
            r_dcnt <= 2'd0;
            r_x    <= 8'd0;
            r_y    <= 7'd0;
            r_addr <= 15'd0;
        end else begin
            r_arm  <= 1'b1;
            r_dcnt <= r_state == DRAIN ? r_dcnt + 2'd1 : 2'd0;
            if (r_state == IDLE) begin
                r_x    <= 8'd0;
                r_y    <= 7'd0;
                r_addr <= 15'd0;
            end else if (w_issue) begin
                r_x    <= r_x == XMAX ? 8'd0 : r_x + 8'd1;
                r_y    <= r_x == XMAX ? r_y + 7'd1 : r_y;
                r_addr <= r_addr + 15'd1;
            end
        end
    end

    // Coordinates travel alongside each read so they meet the RAM data when it returns
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_pv[i] <= 1'b0;
                r_px[i] <= 8'd0;
                r_py[i] <= 7'd0;
            end
        end else begin
            r_pv[0] <= w_issue;
            r_px[0] <= r_x;
            r_py[0] <= r_y;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_px[i] <= r_px[i-1];
                r_py[i] <= r_py[i-1];
            end
        end
    end

    // Retiring read updates the VGA outputs and strobes plot
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_vx   <= 8'd0;
            r_vy   <= 7'd0;
            r_vc   <= '0;
            r_plot <= 1'b0;
        end else begin
            r_plot <= r_pv[RD_LAT-1] && w_show;
            if (r_pv[RD_LAT-1]) begin
                r_vx <= r_px[RD_LAT-1];
                r_vy <= r_py[RD_LAT-1];
                r_vc <= q;
            end
        end
    end
endmodule

// File: tb/tb_frame_scanner.sv
// tb_frame_scanner: checks frame_scanner against a raster-order reference of the frame RAM
module tb_frame_scanner;
    parameter int LAT = 1;
    localparam int NPIX = 19200;

    logic        clk = 1'b0, rstn = 1'b0, enable = 1'b0, start = 1'b0;
    logic        busy, done, wren, plot;
    logic [14:0] addr;
    logic [11:0] q, vc;
    logic [7:0]  vx;
    logic [6:0]  vy;

    logic [11:0] mem [NPIX];
    logic [11:0] qd [LAT];
    int          icyc [NPIX];
    int          checks = 0, errors = 0, cyc = 0;
    int          pidx, issued, nplots, ndone, first_plot, done_cyc, t0;
    logic        prev_busy;

    frame_scanner #(.RD_LAT(LAT)) dut (
        .clock(clk), .resetn(rstn), .enable(enable), .start(start), .busy(busy), .done(done),
        .addr(addr), .wren(wren), .q(q), .VGA_X(vx), .VGA_Y(vy), .VGA_COLOR(vc), .plot(plot)
    );

    always #5 clk = ~clk;

    // Frame RAM with LAT cycles of read latency
    assign q = qd[LAT-1];
    always @(posedge clk) begin
        qd[0] <= addr < 15'd19200 ? mem[addr] : 12'h000;
        for (int i = 1; i < LAT; i++) qd[i] <= qd[i-1];
    end

    function automatic bit keyed(logic [11:0] c);
`ifdef FRAME_SCANNER_TRANSPARENT_EN
        return c == 12'h000;
`else
        return c === 12'hxxx;
`endif
    endfunction

    function automatic int nvis(int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (!keyed(mem[i])) c++;
        return c;
    endfunction

    function automatic int first_vis();
        for (int i = 0; i < NPIX; i++) if (!keyed(mem[i])) return i;
        return NPIX;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        pidx = 0; issued = 0; nplots = 0; ndone = 0; first_plot = -1; done_cyc = -1;
    endtask

    // One clock: record the read issued this cycle, advance, then check plot/done against the raster reference
    task automatic step();
        prev_busy = busy;
        if (busy && enable && issued < NPIX) begin
            chk("addr", 64'(addr), 64'(issued));
            icyc[issued] = cyc;
            issued++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (plot) begin
            while (pidx < NPIX && keyed(mem[pidx])) pidx++;
            if (pidx >= NPIX) chk("extra_plot", 64'(plot), 64'(0));
            else chk("pixel", 64'({vx, vy, vc, 16'(cyc - icyc[pidx])}),
                     64'({8'(pidx % 160), 7'(pidx / 160), mem[pidx], 16'(LAT + 1)}));
            if (first_plot < 0) first_plot = cyc;
            pidx++;
            nplots++;
        end
        if (done) begin
            ndone++;
            done_cyc = cyc;
            chk("busy_at_done", 64'(busy), 64'(0));
            chk("busy_before_done", 64'(prev_busy), 64'(1));
        end
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) mem[i] = 12'(i);
        model_clear();
        step(); step();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_plot", 64'(plot), 64'(0));
        chk("rst_addr", 64'(addr), 64'(0));
        chk("rst_xyc", 64'({vx, vy, vc}), 64'(0));
        chk("rst_wren", 64'(wren), 64'(0));
        // start coinciding with reset release is dropped
        rstn = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("start_at_release", 64'(busy), 64'(0));

        // reset in the middle of a scan at pixel (37,5)
        model_clear();
        enable = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 2000 && addr != 15'd837; i++) step();
        chk("reach_37_5", 64'(addr), 64'(837));
        rstn = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_plot", 64'(plot), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        chk("mid_rst_addr", 64'(addr), 64'(0));
        chk("mid_rst_xyc", 64'({vx, vy, vc}), 64'(0));
        step(); step();
        chk("no_done_after_rst", 64'(ndone), 64'(0));
        rstn = 1'b1;
        step(); step();

        // full frame with a 10-cycle stall at (159,0), a start while busy and a start in the DONE cycle
        model_clear();
        start = 1'b1; t0 = cyc;
        step();
        start = 1'b0;
        for (int i = 0; i < 400 && issued != 159; i++) step();
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_hold", 64'(addr), 64'(159));
        end
        chk("stall_drain", 64'(nplots), 64'(nvis(159)));
        enable = 1'b1;
        step();
        chk("resume_addr", 64'(addr), 64'(160));
        for (int i = 0; i < 30000 && ndone == 0; i++) begin
            start = i == 500;
            step();
        end
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("done_cycle_start", 64'(busy), 64'(0));
        chk("a_done_count", 64'(ndone), 64'(1));
        chk("a_plot_count", 64'(nplots), 64'(nvis(NPIX)));
        chk("a_first_plot", 64'(first_plot - t0), 64'(LAT + 2 + first_vis()));
        chk("a_done_time", 64'(done_cyc - t0), 64'(19211 + LAT));

        // random frame contents and random enable
        for (int i = 0; i < NPIX; i++) mem[i] = 12'($urandom);
        model_clear();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 40000 && ndone == 0; i++) begin
            enable = $urandom_range(0, 3) != 0;
            step();
        end
        enable = 1'b1;
        step();
        chk("b_done_count", 64'(ndone), 64'(1));
        chk("b_issue_count", 64'(issued), 64'(NPIX));
        chk("b_plot_count", 64'(nplots), 64'(nvis(NPIX)));
        chk("b_done_time", 64'(done_cyc), 64'(icyc[NPIX-1] + LAT + 1));
        chk("b_idle", 64'(busy), 64'(0));
        chk("wren", 64'(wren), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
